wide_add_seq: RTL



---
 rtl/wide_add_pkg.sv | 25 ++
 rtl/a1csa32bits.sv | 38 +++
 rtl/wide_add_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/wide_add_pkg.sv
//------------------------------------------------------------------------------
// Module  : wide_add_pkg
// Brief   : Shared constants, FSM state type and slice-count helper for the
//           sequential wide adder.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wide_add_pkg;

    localparam int SLICE_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int slice_count(input int width);
        return width / SLICE_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/a1csa32bits.sv
//------------------------------------------------------------------------------
// Module  : a1csa32bits
// Brief   : 32-bit add-one carry-select adder core (four 8-bit blocks, each
//           selecting between sum and sum+1 on its incoming carry).
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module a1csa32bits (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] s_o,
    output logic        cout_o
);

    localparam int C_BLK_W = 8;
    localparam int C_NBLK  = 32 / C_BLK_W;

    logic [C_NBLK:0] w_c;

    assign w_c[0] = cin_i;

    for (genvar g = 0; g < C_NBLK; g++) begin : g_blk
        logic [C_BLK_W:0] w_sum0;
        logic [C_BLK_W:0] w_sum1;

        assign w_sum0 = {1'b0, a_i[g*C_BLK_W +: C_BLK_W]} + {1'b0, b_i[g*C_BLK_W +: C_BLK_W]};
        assign w_sum1 = w_sum0 + {{C_BLK_W{1'b0}}, 1'b1};
        assign s_o[g*C_BLK_W +: C_BLK_W] = w_c[g] ? w_sum1[C_BLK_W-1:0] : w_sum0[C_BLK_W-1:0];
        assign w_c[g+1] = w_c[g] ? w_sum1[C_BLK_W] : w_sum0[C_BLK_W];
    end

    assign cout_o = w_c[C_NBLK];

endmodule

`default_nettype wire

// File: rtl/wide_add_seq.sv
//------------------------------------------------------------------------------
// Module  : wide_add_seq
// Brief   : W-bit adder that streams 32-bit slices LSB-first through one
//           a1csa32bits core. Optional macro WIDE_ADD_SEQ_OVF_EN adds ovf.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         busy
`ifdef WIDE_ADD_SEQ_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int S    = slice_count(W);
    localparam int IDXW = (S > 1) ? $clog2(S) : 1;

    state_t            state_q, state_d;
    logic [W-1:0]      a_q, b_q, s_q;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q, cout_q, out_valid_q;
    logic [SLICE_W-1:0] w_a_slice, w_b_slice, w_core_s;
    logic              w_core_cout;
    logic              w_last, w_accept;

    assign w_last   = (idx_q == IDXW'(S - 1));
    assign w_accept = in_valid & in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (w_last) state_d = DONE;
            DONE:    if (out_ready) state_d = in_valid ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic; DONE hands in_ready over to the consumer for back-to-back use
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            RUN:     busy     = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int k = 0; k < S; k++) begin
            if (idx_q == IDXW'(k)) begin
                w_a_slice = a_q[k*SLICE_W +: SLICE_W];
                w_b_slice = b_q[k*SLICE_W +: SLICE_W];
            end
        end
    end

    a1csa32bits u_core (
        .a_i    (w_a_slice),
        .b_i    (w_b_slice),
        .cin_i  (carry_q),
        .s_o    (w_core_s),
        .cout_o (w_core_cout)
    );

`ifdef WIDE_ADD_SEQ_OVF_EN
    logic ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef WIDE_ADD_SEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= cin;
                idx_q   <= '0;
            end
            if (state_q == RUN) begin
                for (int k = 0; k < S; k++) begin
                    if (idx_q == IDXW'(k)) s_q[k*SLICE_W +: SLICE_W] <= w_core_s;
                end
                carry_q <= w_core_cout;
                if (w_last) begin
                    cout_q      <= w_core_cout;
                    out_valid_q <= 1'b1;
`ifdef WIDE_ADD_SEQ_OVF_EN
                    ovf_q <= (a_q[W-1] == b_q[W-1]) & (w_core_s[SLICE_W-1] != a_q[W-1]);
`endif
                end else begin
                    idx_q <= idx_q + IDXW'(1);
                end
            end
            if (state_q == DONE && out_ready) out_valid_q <= 1'b0;
        end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;
`ifdef WIDE_ADD_SEQ_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

`default_nettype wire
